// File: rtl/serial_word_loader_if.sv
// Bundle of the serial framing inputs and the word-load outputs of
// serial_word_loader. The slave modport is the loader itself; the master
// modport is whatever produces the bit stream and consumes the word.
interface serial_word_loader_if #(
    parameter int N = 4
);
    logic         sen;
    logic         sdi;
    logic         frm;
    logic         load;
    logic [N-1:0] word;
    logic         busy;
    logic         err;

    modport master (
        output sen, sdi, frm,
        input  load, word, busy, err
    );

    modport slave (
        input  sen, sdi, frm,
        output load, word, busy, err
    );
endinterface

// File: rtl/serial_word_loader.sv
// Serial-to-parallel word loader: assembles an N-bit MSB-first word from a
// strobed bit stream and hands it to a downstream load register with a
// one-cycle load strobe. A frame start inside a frame aborts it (err pulse)
// and restarts assembly from the sampled bit.
// Optional macro PARITY_EN: a trailing even-parity bit follows the N data
// bits; a parity failure pulses err instead of load.
module serial_word_loader #(
    parameter int N  = 4,
    parameter int CW = 3
) (
    input  logic              ck,
    input  logic              rn,
    serial_word_loader_if.slave bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
`ifdef PARITY_EN
    localparam logic [1:0] ST_PAR   = 2'd2;
`endif
    // Counter value seen on the edge that samples the final data bit.
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    logic [1:0]    state_q, state_d;
    logic [N-1:0]  sr_q, sr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  word_q, word_d;
    logic          load_q, load_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;
    logic [N-1:0]  sr_next;

    // Shift register with the current bit written at its MSB-first slot.
    always_comb begin
        sr_next = sr_q;
        for (int i = 0; i < N; i++) begin
            if (cnt_q == CW'(N - 1 - i)) begin
                sr_next[i] = bus.sdi;
            end
        end
    end

    // Framing state machine and next-value computation for all registers.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        load_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.sen && bus.frm) begin
                    sr_d    = {bus.sdi, {(N-1){1'b0}}};
                    cnt_d   = CW'(1);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bus.sen && bus.frm) begin
                    err_d   = 1'b1;
                    sr_d    = {bus.sdi, {(N-1){1'b0}}};
                    cnt_d   = CW'(1);
                end else if (bus.sen) begin
                    sr_d  = sr_next;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
`ifdef PARITY_EN
                        state_d = ST_PAR;
`else
                        word_d  = sr_next;
                        load_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
`endif
                    end
                end
            end
`ifdef PARITY_EN
            ST_PAR: begin
                if (bus.sen && bus.frm) begin
                    err_d   = 1'b1;
                    sr_d    = {bus.sdi, {(N-1){1'b0}}};
                    cnt_d   = CW'(1);
                    state_d = ST_SHIFT;
                end else if (bus.sen) begin
                    // Even parity: data bits XOR parity bit must be zero.
                    if (((^sr_q) ^ bus.sdi) == 1'b0) begin
                        word_d = sr_q;
                        load_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset discards any partial frame.
    always_ff @(posedge ck or posedge rn) begin
        if (rn) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            load_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            load_q  <= load_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.load = load_q;
    assign bus.word = word_q;
    assign bus.busy = busy_q;
    assign bus.err  = err_q;
endmodule

// File: tb/tb_serial_word_loader.sv
// Scoreboard bench for serial_word_loader. A frame-level reference model
// turns each strobed bit into expected load/err events; a monitor compares
// them against the DUT strobes, and tracks busy/word every cycle.
module tb_serial_word_loader;
    localparam int N  = 4;
    localparam int CW = 3;

    logic ck = 1'b0;
    logic rn = 1'b0;

    serial_word_loader_if #(.N(N)) bus ();

    serial_word_loader #(.N(N), .CW(CW)) dut (
        .ck  (ck),
        .rn  (rn),
        .bus (bus)
    );

    always #5 ck = ~ck;

    typedef struct packed {
        logic         is_err;
        logic [N-1:0] w;
    } exp_t;

    exp_t         sb[$];
    bit           frame[$];
    bit           in_frame;
    logic [N-1:0] exp_word;
    bit           exp_busy;
    bit           mon_en;
    int           n_checks;
    int           n_pass;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    endtask

    function automatic logic [N-1:0] pack_frame();
        logic [N-1:0] w = '0;
        foreach (frame[i]) w = {w[N-2:0], frame[i]};
        return w;
    endfunction

    task automatic model_reset();
        frame.delete();
        in_frame = 1'b0;
        exp_word = '0;
        exp_busy = 1'b0;
        sb.delete();
    endtask

    // Frame-level reference: what the coming clock edge should produce.
    task automatic model_edge(input bit s, input bit d, input bit f);
        exp_t e;
        if (!s) return;
        if (f) begin
            if (in_frame) begin
                e.is_err = 1'b1;
                e.w      = exp_word;
                sb.push_back(e);
            end
            frame.delete();
            frame.push_back(d);
            in_frame = 1'b1;
        end else if (in_frame) begin
`ifdef PARITY_EN
            if (frame.size() < N) begin
                frame.push_back(d);
            end else begin
                bit p = d;
                foreach (frame[i]) p ^= frame[i];
                if (!p) begin
                    exp_word = pack_frame();
                    e.is_err = 1'b0;
                end else begin
                    e.is_err = 1'b1;
                end
                e.w = exp_word;
                sb.push_back(e);
                in_frame = 1'b0;
            end
`else
            frame.push_back(d);
            if (frame.size() == N) begin
                exp_word = pack_frame();
                e.is_err = 1'b0;
                e.w      = exp_word;
                sb.push_back(e);
                in_frame = 1'b0;
            end
`endif
        end
        exp_busy = in_frame;
    endtask

    task automatic tick(input bit s, input bit d, input bit f);
        @(negedge ck);
        bus.sen = s;
        bus.sdi = d;
        bus.frm = f;
        if (!rn) model_edge(s, d, f);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'($urandom), 1'($urandom));
    endtask

    task automatic send(input logic [N-1:0] w);
        for (int i = N - 1; i >= 0; i--) tick(1'b1, w[i], i == N - 1);
`ifdef PARITY_EN
        tick(1'b1, ^w, 1'b0);
`endif
    endtask

    // Monitor: pops the scoreboard on each strobe, checks busy/word always.
    always @(posedge ck) begin : monitor
        exp_t e;
        #1;
        if (mon_en) begin
            chk("load_err_exclusive", 32'(bus.load & bus.err), 32'd0);
            if (bus.load || bus.err) begin
                if (sb.size() == 0) begin
                    chk("spurious_strobe", 32'({bus.load, bus.err}), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("strobe_is_err", 32'(bus.err), 32'(e.is_err));
                    if (bus.load) chk("load_word", 32'(bus.word), 32'(e.w));
                end
            end
            if (sb.size() != 0) begin
                chk("missing_strobe", 32'(sb.size()), 32'd0);
                sb.delete();
            end
            chk("busy", 32'(bus.busy), 32'(exp_busy));
            chk("word", 32'(bus.word), 32'(exp_word));
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        mon_en   = 1'b0;
        model_reset();
        bus.sen = 1'b0;
        bus.sdi = 1'b0;
        bus.frm = 1'b0;
        #1 rn = 1'b1;

        // Reset with random inputs toggling.
        tick(1'b1, 1'b1, 1'b1);
        mon_en = 1'b1;
        repeat (4) tick(1'($urandom), 1'($urandom), 1'($urandom));
        chk("reset_load", 32'(bus.load), 32'd0);
        chk("reset_word", 32'(bus.word), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_err",  32'(bus.err),  32'd0);
        @(negedge ck);
        rn      = 1'b0;
        bus.sen = 1'b0;
        idle(5);

        // Basic frame.
        send(4'b1011);
        idle(2);

        // Gapped strobe 1,1,0,0 with gaps of 0, 3 and 7 cycles.
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b0);
        idle(3);
        tick(1'b1, 1'b0, 1'b0);
        idle(7);
        tick(1'b1, 1'b0, 1'b0);
`ifdef PARITY_EN
        tick(1'b1, 1'b0, 1'b0);
`endif
        idle(2);

        // Abort after two bits, then back-to-back frames.
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 1'b0);
        send(4'b0110);
        send(4'b1111);
        idle(2);

        // Reset mid-frame, checked before the next clock edge.
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        @(posedge ck);
        #3;
        rn = 1'b1;
        model_reset();
        #1;
        chk("async_reset_busy", 32'(bus.busy), 32'd0);
        chk("async_reset_word", 32'(bus.word), 32'd0);
        idle(2);
        @(negedge ck);
        rn      = 1'b0;
        bus.sen = 1'b0;
        idle(2);
        send(4'b0001);
        idle(2);

`ifdef PARITY_EN
        // Good parity loads; bad parity errors and keeps the old word.
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        idle(2);
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        idle(2);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            tick(1'($urandom_range(0, 1)), 1'($urandom), ($urandom_range(0, 7) == 0));
        end
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
